// File: rtl/control_sequencer_if.sv
// Handshake/bus bundle between the multicycle MIPS datapath and its microstate sequencer.
// The sequencer attaches through the slave modport; the datapath (or a bench) uses master.
interface control_sequencer_if;
  logic [6:0] state_sel;
  logic       moc;
  logic       cond;
  logic [6:0] state;
  logic       mar_ld;
  logic       ir_ld;
  logic       pc_ld;
  logic       pc_sel;
  logic       mem_en;
  logic       mem_rw;
  logic       rf_ld;
  logic       illegal;
  logic       bus_err;

  modport master (
    output state_sel, moc, cond,
    input  state, mar_ld, ir_ld, pc_ld, pc_sel, mem_en, mem_rw, rf_ld, illegal, bus_err
  );

  modport slave (
    input  state_sel, moc, cond,
    output state, mar_ld, ir_ld, pc_ld, pc_sel, mem_en, mem_rw, rf_ld, illegal, bus_err
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore microstate sequencer for the multicycle MIPS datapath: fetch/decode/execute,
// memory MOC handshake with a bounded wait, illegal-opcode and sticky bus-error states.
module control_sequencer #(
  parameter int unsigned MOC_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input logic                clk,
  input logic                reset,
  control_sequencer_if.slave bus
);

  typedef enum logic [6:0] {
    S_RESET      = 7'd0,
    S_FETCH_ADDR = 7'd1,
    S_FETCH_WAIT = 7'd2,
    S_FETCH_IR   = 7'd3,
    S_DECODE     = 7'd4,
    S_ALU        = 7'd6,
    S_STORE_ADDR = 7'd7,
    S_STORE_WAIT = 7'd8,
    S_BRANCH     = 7'd11,
    S_BR_TAKEN   = 7'd12,
    S_LOAD_ADDR  = 7'd13,
    S_LOAD_WAIT  = 7'd14,
    S_LOAD_WB    = 7'd15,
    S_ALU_LO     = 7'd17,
    S_ALU_HI     = 7'd35,
    S_BR37       = 7'd37,
    S_BR39       = 7'd39,
    S_BR41       = 7'd41,
    S_ILLEGAL    = 7'd62,
    S_BUS_ERR    = 7'd63
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MOC_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q) inside
      S_RESET:      state_d = S_FETCH_ADDR;
      // Address states are the only predecessors of the wait states, so the counter is cleared here.
      S_FETCH_ADDR: begin state_d = S_FETCH_WAIT; cnt_d = '0; end
      S_STORE_ADDR: begin state_d = S_STORE_WAIT; cnt_d = '0; end
      S_LOAD_ADDR:  begin state_d = S_LOAD_WAIT;  cnt_d = '0; end
      S_FETCH_WAIT, S_STORE_WAIT, S_LOAD_WAIT: begin
        if (bus.moc) begin
          case (state_q)
            S_FETCH_WAIT: state_d = S_FETCH_IR;
            S_STORE_WAIT: state_d = S_FETCH_ADDR;
            default:      state_d = S_LOAD_WB;
          endcase
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_BUS_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH_IR:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.state_sel) inside
          7'd6, 7'd7, 7'd11, 7'd13, [7'd17:7'd35], 7'd37, 7'd39, 7'd41:
                   state_d = state_e'(bus.state_sel);
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_ALU, [S_ALU_LO:S_ALU_HI], S_LOAD_WB, S_BR_TAKEN, S_ILLEGAL:
                    state_d = S_FETCH_ADDR;
      S_BRANCH, S_BR37, S_BR39, S_BR41:
                    state_d = bus.cond ? S_BR_TAKEN : S_FETCH_ADDR;
      S_BUS_ERR:    state_d = S_BUS_ERR;
      default:      state_d = S_RESET;
    endcase
  end

  always_comb begin
    bus.state   = state_q;
    bus.mar_ld  = 1'b0;
    bus.ir_ld   = 1'b0;
    bus.pc_ld   = 1'b0;
    bus.pc_sel  = 1'b0;
    bus.mem_en  = 1'b0;
    bus.mem_rw  = 1'b0;
    bus.rf_ld   = 1'b0;
    bus.illegal = 1'b0;
    bus.bus_err = 1'b0;
    case (state_q) inside
      S_FETCH_ADDR, S_STORE_ADDR, S_LOAD_ADDR: bus.mar_ld = 1'b1;
      S_FETCH_WAIT, S_LOAD_WAIT: begin bus.mem_en = 1'b1; bus.mem_rw = 1'b1; end
      S_STORE_WAIT: bus.mem_en = 1'b1;
      S_FETCH_IR:   begin bus.ir_ld = 1'b1; bus.pc_ld = 1'b1; end
      S_ALU, [S_ALU_LO:S_ALU_HI], S_LOAD_WB: bus.rf_ld = 1'b1;
      S_BR_TAKEN:   begin bus.pc_ld = 1'b1; bus.pc_sel = 1'b1; end
      S_ILLEGAL:    bus.illegal = 1'b1;
      S_BUS_ERR:    bus.bus_err = 1'b1;
      default: ;
    endcase
  end

endmodule
